// File: rtl/terrain_pkg.sv
// Shared widths, engine states and the chord-search helper for the terrain column generator.
package terrain_pkg;
  localparam int unsigned NUM_COLS    = 640;
  localparam int unsigned NUM_ROWS    = 480;
  localparam int unsigned HEIGHT_W    = 10;
  localparam int unsigned COL_W       = 10;
  localparam int unsigned ROW_W       = 9;
  localparam int unsigned INIT_HEIGHT = 400;
  localparam int unsigned MAX_R       = 63;
  localparam int unsigned R_W         = 6;
  localparam int unsigned DX_W        = 11;
  localparam int unsigned SQ_W        = 13;

  typedef enum logic [2:0] {INIT, IDLE, RD, RDW, SRCH, WR, DONE} eng_state_t;

  // True while (dx, h) still lies outside the crater circle; squaring a sign-extended dx mod 2^13 is exact here.
  function automatic logic chord_outside(input logic [R_W-1:0] h,
                                         input logic signed [DX_W-1:0] dx,
                                         input logic [R_W-1:0] r);
    logic [SQ_W-1:0] hh, dd, rr, dxe;
    dxe = {{(SQ_W-DX_W){dx[DX_W-1]}}, dx};
    hh  = SQ_W'(h) * SQ_W'(h);
    dd  = dxe * dxe;
    rr  = SQ_W'(r) * SQ_W'(r);
    return (hh + dd) > rr;
  endfunction
endpackage

// File: rtl/terrain_column_gen_if.sv
// Crater request/status bundle between game logic (master) and the terrain engine (slave).
interface terrain_column_gen_if;
  import terrain_pkg::*;
  logic             crater_req;
  logic [COL_W-1:0] crater_x;
  logic [ROW_W-1:0] crater_y;
  logic [R_W-1:0]   crater_r;
  logic             crater_ready;
  logic             crater_done;
  logic             busy;

  modport master (output crater_req, crater_x, crater_y, crater_r,
                  input  crater_ready, crater_done, busy);
  modport slave  (input  crater_req, crater_x, crater_y, crater_r,
                  output crater_ready, crater_done, busy);
endinterface

// File: rtl/terrain_height_ram.sv
// Heightmap storage: true dual-port 640x10 RAM, registered read on both ports.
module terrain_height_ram
  import terrain_pkg::*;
(
  input  logic                clk,
  input  logic [COL_W-1:0]    i_a_addr,
  output logic [HEIGHT_W-1:0] o_a_rdata,
  input  logic                i_b_we,
  input  logic [COL_W-1:0]    i_b_addr,
  input  logic [HEIGHT_W-1:0] i_b_wdata,
  output logic [HEIGHT_W-1:0] o_b_rdata
);
  logic [HEIGHT_W-1:0] r_mem [NUM_COLS];

  always_ff @(posedge clk) begin
    o_a_rdata <= r_mem[i_a_addr];
    o_b_rdata <= r_mem[i_b_addr];
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
  end
endmodule

// File: rtl/terrain_column_gen.sv
// Destructible terrain heightmap: per-pixel column mask plus crater-carving engine.
// Optional TERRAIN_HILLS_EN: INIT writes a triangle-wave profile instead of a flat surface.
module terrain_column_gen
  import terrain_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [COL_W-1:0]    DrawX,
  output logic [NUM_ROWS-1:0] terrain_data,
  terrain_column_gen_if.slave crater
);
  localparam int unsigned          BOT_W     = HEIGHT_W + 1;
  localparam logic [NUM_ROWS-1:0]  ROWS_ONES = '1;
  localparam logic signed [DX_W-1:0] DX_ONE  = DX_W'(1);

  eng_state_t             r_state;
  logic [COL_W-1:0]       r_col, r_x;
  logic [ROW_W-1:0]       r_y;
  logic [R_W-1:0]         r_r, r_h;
  logic signed [DX_W-1:0] r_dx;
  logic [HEIGHT_W-1:0]    r_hcol;
  logic                   r_ready, r_done, r_busy, r_disp_valid;

  logic                   w_drawx_ok, w_cx_ok, w_last, w_b_we;
  logic [COL_W-1:0]       w_a_addr, w_b_addr;
  logic [HEIGHT_W-1:0]    w_a_rdata, w_b_rdata, w_b_wdata, w_init_h, w_bot, w_new_h;
  logic signed [DX_W:0]   w_cx;
  logic [BOT_W-1:0]       w_bot_raw;

  assign w_drawx_ok = DrawX < COL_W'(NUM_COLS);
  assign w_a_addr   = w_drawx_ok ? DrawX : '0;

  // Carve column and its clipped crater floor
  assign w_cx      = $signed({2'b00, r_x}) + $signed({r_dx[DX_W-1], r_dx});
  assign w_cx_ok   = !w_cx[DX_W] && (w_cx[DX_W-1:0] < DX_W'(NUM_COLS));
  assign w_last    = (r_dx == $signed({{(DX_W-R_W){1'b0}}, r_r}));
  assign w_bot_raw = BOT_W'(r_y) + BOT_W'(r_h) + BOT_W'(1);
  assign w_bot     = (w_bot_raw > BOT_W'(NUM_ROWS)) ? HEIGHT_W'(NUM_ROWS) : w_bot_raw[HEIGHT_W-1:0];
  assign w_new_h   = (r_hcol > w_bot) ? r_hcol : w_bot;

  assign w_b_we    = (r_state == INIT) || (r_state == WR);
  assign w_b_addr  = (r_state == INIT) ? r_col : w_cx[COL_W-1:0];
  assign w_b_wdata = (r_state == INIT) ? w_init_h : w_new_h;

  assign terrain_data        = r_disp_valid ? (ROWS_ONES << w_a_rdata) : '0;
  assign crater.crater_ready = r_ready;
  assign crater.crater_done  = r_done;
  assign crater.busy         = r_busy;

  terrain_height_ram u_ram (
    .clk       (clk),
    .i_a_addr  (w_a_addr),
    .o_a_rdata (w_a_rdata),
    .i_b_we    (w_b_we),
    .i_b_addr  (w_b_addr),
    .i_b_wdata (w_b_wdata),
    .o_b_rdata (w_b_rdata)
  );

`ifdef TERRAIN_HILLS_EN
  logic [HEIGHT_W-1:0] r_hill;
  logic                r_hill_up;
  logic [5:0]          r_hill_step;

  // Triangle profile: 64 columns down, 64 up, starting at INIT_HEIGHT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hill      <= HEIGHT_W'(INIT_HEIGHT);
      r_hill_up   <= 1'b0;
      r_hill_step <= '0;
    end else if (r_state == INIT) begin
      r_hill      <= r_hill_up ? r_hill + HEIGHT_W'(1) : r_hill - HEIGHT_W'(1);
      r_hill_step <= r_hill_step + 6'd1;
      if (r_hill_step == 6'd63) r_hill_up <= ~r_hill_up;
    end
  end
  assign w_init_h = r_hill;
`else
  assign w_init_h = HEIGHT_W'(INIT_HEIGHT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= INIT;
      r_col        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_r          <= '0;
      r_h          <= '0;
      r_dx         <= '0;
      r_hcol       <= '0;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_disp_valid <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_disp_valid <= (r_state != INIT) && w_drawx_ok;
      case (r_state)
        INIT: begin
          r_busy <= 1'b1;
          r_col  <= r_col + COL_W'(1);
          if (r_col == COL_W'(NUM_COLS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        IDLE: if (crater.crater_req && r_ready) begin
          r_x     <= crater.crater_x;
          r_y     <= crater.crater_y;
          r_r     <= crater.crater_r;
          r_dx    <= -$signed({{(DX_W-R_W){1'b0}}, crater.crater_r});
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= RD;
        end
        RD: begin
          if (w_cx_ok) begin
            r_state <= RDW;
          end else if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_dx <= r_dx + DX_ONE;
          end
        end
        RDW: begin
          r_hcol  <= w_b_rdata;
          r_h     <= r_r;
          r_state <= SRCH;
        end
        SRCH: begin
          if (chord_outside(r_h, r_dx, r_r)) r_h <= r_h - R_W'(1);
          else                               r_state <= WR;
        end
        WR: begin
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_dx    <= r_dx + DX_ONE;
            r_state <= RD;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= INIT;
      endcase
    end
  end
endmodule
